// File: rtl/uart_axil_regs.sv
// uart_axil_regs
//   AXI4-Lite slave register front-end for the UART FIFO core. It decodes four
//   32-bit registers, turns TXDATA writes into one-cycle tx_we pushes and
//   RXDATA reads into one-cycle rx_re pops, keeps a sticky TX_DROP flag, and
//   (optionally) drives a registered interrupt.
//
//   Register map (byte offset):
//     0x0 STATUS  RO  {27'b0, tx_drop, tx_full, tx_empty, rx_full, rx_empty}
//     0x4 TXDATA  WO  push wdata[7:0] if !tx_full, else set TX_DROP; reads 0
//     0x8 RXDATA  RO  {24'b0, rx_data} + pop if !rx_empty, else 32'h100
//     0xC CTRL    RW  bit4 W1C clears TX_DROP; bits[2:0] IE mask (irq build)
//
//   Optional feature macro: UART_AXIL_IRQ_EN (adds the irq port and the IE
//   mask). Without it, CTRL[2:0] read 0 and ignore writes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   irq                 interrupt (UART_AXIL_IRQ_EN only)
//   s_axi_aw*/w*/b*     AXI4-Lite write address / data / response channels
//   s_axi_ar*/r*        AXI4-Lite read address / data channels
//   rx_empty/rx_full    RX FIFO status; rx_data is the show-ahead head
//   tx_empty/tx_full    TX FIFO status
//   rx_re, tx_we        one-cycle pop / push strobes; tx_data is push data
//
// state  | meaning
// W_IDLE | waiting for awvalid and wvalid together
// W_ACK  | one cycle: awready/wready high, register effect / tx_we
// W_RESP | bvalid high until bready
// R_IDLE | waiting for arvalid
// R_ACK  | one cycle: arready high, rdata captured, rx_re
// R_DATA | rvalid high, rdata held until rready

module uart_axil_regs #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef UART_AXIL_IRQ_EN
    output logic                    irq,
`endif
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic                    rx_empty,
    input  logic                    rx_full,
    input  logic                    tx_empty,
    input  logic                    tx_full,
    input  logic [7:0]              rx_data,
    output logic                    rx_re,
    output logic [7:0]              tx_data,
    output logic                    tx_we
);

    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_TXDATA = 2'd1;
    localparam logic [1:0] OFF_RXDATA = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [1:0] w_off;
    logic       w_err;
    logic       w_strb0;
    logic [7:0] w_lo;
    logic [1:0] r_off;
    logic       r_err;
    logic       tx_drop;

    logic       aw_hi;
    logic       ar_hi;
    logic       w_fire;
    logic       drop_set;
    logic       drop_clr;
    logic [DATA_WIDTH-1:0] rd_mux;

    // Address bits above the 16-byte window only exist for wider buses; any
    // nonzero value there is unmapped space.
    generate
        if (ADDR_WIDTH > 4) begin : g_hi
            assign aw_hi = |s_axi_awaddr[ADDR_WIDTH-1:4];
            assign ar_hi = |s_axi_araddr[ADDR_WIDTH-1:4];
        end else begin : g_no_hi
            assign aw_hi = 1'b0;
            assign ar_hi = 1'b0;
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{s_axi_wdata[DATA_WIDTH-1:8], s_axi_wstrb[DATA_WIDTH/8-1:1],
                           s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // The write captured in W_IDLE takes effect in the W_ACK cycle; FIFO
    // flags are looked at live in that cycle.
    assign w_fire   = (w_state == W_ACK) && !w_err && w_strb0;
    assign tx_we    = w_fire && (w_off == OFF_TXDATA) && !tx_full;
    assign drop_set = w_fire && (w_off == OFF_TXDATA) && tx_full;
    assign drop_clr = w_fire && (w_off == OFF_CTRL) && w_lo[4];
    assign tx_data  = w_lo;

    assign rx_re = (r_state == R_ACK) && !r_err && (r_off == OFF_RXDATA) && !rx_empty;

`ifdef UART_AXIL_IRQ_EN
    logic [2:0] ie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie  <= 3'b000;
            irq <= 1'b0;
        end else begin
            if (w_fire && (w_off == OFF_CTRL)) begin
                ie <= w_lo[2:0];
            end
            irq <= (ie[0] & !rx_empty) | (ie[1] & tx_empty) | (ie[2] & tx_drop);
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (!r_err) begin
            case (r_off)
                OFF_STATUS: rd_mux[4:0] = {tx_drop, tx_full, tx_empty, rx_full, rx_empty};
                OFF_RXDATA: begin
                    if (rx_empty) begin
                        rd_mux[8] = 1'b1;
                    end else begin
                        rd_mux[7:0] = rx_data;
                    end
                end
                OFF_CTRL: begin
`ifdef UART_AXIL_IRQ_EN
                    rd_mux[2:0] = ie;
`endif
                end
                default: rd_mux = '0;
            endcase
        end
    end

    // A set and a clear can never coincide from a single write channel, but
    // set wins regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_drop <= 1'b0;
        end else if (drop_set) begin
            tx_drop <= 1'b1;
        end else if (drop_clr) begin
            tx_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            w_off         <= 2'd0;
            w_err         <= 1'b0;
            w_strb0       <= 1'b0;
            w_lo          <= 8'h00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_wvalid) begin
                        w_state       <= W_ACK;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        w_off         <= s_axi_awaddr[3:2];
                        w_err         <= aw_hi;
                        w_strb0       <= s_axi_wstrb[0];
                        w_lo          <= s_axi_wdata[7:0];
                    end
                end
                W_ACK: begin
                    w_state       <= W_RESP;
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b1;
                    s_axi_bresp   <= w_err ? RESP_SLVERR : RESP_OKAY;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state      <= W_IDLE;
                        s_axi_bvalid <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
            r_off         <= 2'd0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        r_state       <= R_ACK;
                        s_axi_arready <= 1'b1;
                        r_off         <= s_axi_araddr[3:2];
                        r_err         <= ar_hi;
                    end
                end
                R_ACK: begin
                    r_state       <= R_DATA;
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b1;
                    s_axi_rresp   <= r_err ? RESP_SLVERR : RESP_OKAY;
                    s_axi_rdata   <= rd_mux;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_state      <= R_IDLE;
                        s_axi_rvalid <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axil_regs.sv
// Testbench for uart_axil_regs: directed vector table, hand-written
// multi-cycle sequences (back-pressure, simultaneous read/write, reset in
// W_RESP, optional irq), and randomized transactions against a register-level
// reference model.
module tb_uart_axil_regs;

    logic        clk;
    logic        rst_n;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic [7:0]  rx_data;
    logic        rx_re;
    logic [7:0]  tx_data;
    logic        tx_we;
`ifdef UART_AXIL_IRQ_EN
    logic        irq;
`endif

    uart_axil_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef UART_AXIL_IRQ_EN
        .irq(irq),
`endif
        .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .rx_empty(rx_empty),
        .rx_full(rx_full),
        .tx_empty(tx_empty),
        .tx_full(tx_full),
        .rx_data(rx_data),
        .rx_re(rx_re),
        .tx_data(tx_data),
        .tx_we(tx_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Strobe monitor: counts pushes/pops and remembers when they happened.
    int          we_cnt = 0;
    int          re_cnt = 0;
    logic [7:0]  last_tx = 8'h00;
    int          cyc = 0;
    int          we_cyc = -1;
    int          re_cyc = -2;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (tx_we === 1'b1) begin
            we_cnt  = we_cnt + 1;
            last_tx = tx_data;
            we_cyc  = cyc;
        end
        if (rx_re === 1'b1) begin
            re_cnt = re_cnt + 1;
            re_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic lat_ok);
        int rdy_lat;
        int b_lat;
        rdy_lat = -1;
        b_lat   = -1;
        resp    = 2'b11;
        @(negedge clk);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (s_axi_awready && s_axi_wready && rdy_lat < 0) rdy_lat = i;
            if (s_axi_bvalid) begin
                b_lat = i;
                resp  = s_axi_bresp;
                break;
            end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        lat_ok = (rdy_lat == 1) && (b_lat == 2);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic lat_ok);
        int rdy_lat;
        int r_lat;
        rdy_lat = -1;
        r_lat   = -1;
        resp    = 2'b11;
        data    = 32'hDEAD_BEEF;
        @(negedge clk);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (s_axi_arready && rdy_lat < 0) rdy_lat = i;
            if (s_axi_rvalid) begin
                r_lat = i;
                resp  = s_axi_rresp;
                data  = s_axi_rdata;
                break;
            end
        end
        s_axi_arvalid = 1'b0;
        lat_ok = (rdy_lat == 1) && (r_lat == 2);
    endtask

    task automatic set_flags(input logic rxe, input logic rxf, input logic txe,
                             input logic txf, input logic [7:0] rxd);
        rx_empty = rxe;
        rx_full  = rxf;
        tx_empty = txe;
        tx_full  = txf;
        rx_data  = rxd;
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        rxe, rxf, txe, txf;
        logic [7:0]  rxd;
        logic [31:0] exp_rdata;
        int          exp_we;
        int          exp_re;
        logic [7:0]  exp_tx;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [1:0]  resp;
        logic        lok;
        logic [31:0] rd;
        int          we0, re0;
        logic        m_drop;
        logic [2:0]  m_ie;
        logic        ok;
        logic [31:0] held;

        rst_n = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        set_flags(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        //             wr addr   data          strb  rxe rxf txe txf rxd    exp_rdata     we re tx
        vecs[0]  = '{1'b1, 4'h4, 32'h0000_0041, 4'hF, 1, 0, 1, 0, 8'h00, 32'h0000_0000, 1, 0, 8'h41};
        vecs[1]  = '{1'b0, 4'h8, 32'h0,         4'h0, 0, 0, 1, 0, 8'h5A, 32'h0000_005A, 0, 1, 8'h00};
        vecs[2]  = '{1'b0, 4'h8, 32'h0,         4'h0, 1, 0, 1, 0, 8'h5A, 32'h0000_0100, 0, 0, 8'h00};
        vecs[3]  = '{1'b1, 4'h4, 32'h0000_0099, 4'hF, 1, 0, 0, 1, 8'h00, 32'h0000_0000, 0, 0, 8'h00};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,         4'h0, 1, 0, 0, 1, 8'h00, 32'h0000_0019, 0, 0, 8'h00};
        vecs[5]  = '{1'b1, 4'hC, 32'h0000_0010, 4'h1, 1, 0, 0, 1, 8'h00, 32'h0000_0000, 0, 0, 8'h00};
        vecs[6]  = '{1'b0, 4'h0, 32'h0,         4'h0, 1, 0, 1, 0, 8'h00, 32'h0000_0005, 0, 0, 8'h00};
        vecs[7]  = '{1'b1, 4'h8, 32'h0000_0077, 4'hF, 0, 0, 1, 0, 8'h77, 32'h0000_0000, 0, 0, 8'h00};
        vecs[8]  = '{1'b1, 4'h0, 32'hFFFF_FFE8, 4'hF, 1, 0, 1, 0, 8'h00, 32'h0000_0000, 0, 0, 8'h00};
        vecs[9]  = '{1'b0, 4'h4, 32'h0,         4'h0, 1, 0, 1, 0, 8'h00, 32'h0000_0000, 0, 0, 8'h00};
        vecs[10] = '{1'b0, 4'hC, 32'h0,         4'h0, 1, 0, 1, 0, 8'h00, 32'h0000_0000, 0, 0, 8'h00};
        vecs[11] = '{1'b0, 4'h0, 32'h0,         4'h0, 0, 1, 0, 0, 8'h00, 32'h0000_0002, 0, 0, 8'h00};
        vecs[12] = '{1'b1, 4'h4, 32'h0000_00A5, 4'hE, 1, 0, 1, 0, 8'h00, 32'h0000_0000, 0, 0, 8'h00};
        vecs[13] = '{1'b1, 4'h4, 32'h0000_00A6, 4'hE, 1, 0, 0, 1, 8'h00, 32'h0000_0000, 0, 0, 8'h00};
        vecs[14] = '{1'b0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 1, 8'h00, 32'h0000_0008, 0, 0, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_awready", {31'b0, s_axi_awready}, 32'd0);
        chk("rst_wready",  {31'b0, s_axi_wready},  32'd0);
        chk("rst_bvalid",  {31'b0, s_axi_bvalid},  32'd0);
        chk("rst_arready", {31'b0, s_axi_arready}, 32'd0);
        chk("rst_rvalid",  {31'b0, s_axi_rvalid},  32'd0);
        chk("rst_resps",   {28'b0, s_axi_bresp, s_axi_rresp}, 32'd0);
        chk("rst_rdata",   s_axi_rdata, 32'd0);
        chk("rst_strobes", {30'b0, tx_we, rx_re}, 32'd0);
        chk("rst_txdata",  {24'b0, tx_data}, 32'd0);
`ifdef UART_AXIL_IRQ_EN
        chk("rst_irq", {31'b0, irq}, 32'd0);
`endif
        rst_n = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 15; v++) begin
            set_flags(vecs[v].rxe, vecs[v].rxf, vecs[v].txe, vecs[v].txf, vecs[v].rxd);
            we0 = we_cnt;
            re0 = re_cnt;
            if (vecs[v].wr) begin
                axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, lok);
                chk($sformatf("vec%0d_bresp", v), {30'b0, resp}, 32'd0);
            end else begin
                axi_read(vecs[v].addr, rd, resp, lok);
                chk($sformatf("vec%0d_rresp", v), {30'b0, resp}, 32'd0);
                chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            end
            chk($sformatf("vec%0d_latency", v), {31'b0, lok}, 32'd1);
            chk($sformatf("vec%0d_tx_we_count", v), we_cnt - we0, vecs[v].exp_we);
            chk($sformatf("vec%0d_rx_re_count", v), re_cnt - re0, vecs[v].exp_re);
            if (vecs[v].exp_we != 0)
                chk($sformatf("vec%0d_tx_data", v), {24'b0, last_tx}, {24'b0, vecs[v].exp_tx});
        end

        // Simultaneous RXDATA read and TXDATA write.
        set_flags(1'b0, 1'b0, 1'b1, 1'b0, 8'h6B);
        we0 = we_cnt;
        re0 = re_cnt;
        begin
            logic [1:0] bresp_s, rresp_s;
            logic       wlok, rlok;
            logic [31:0] rd_s;
            fork
                axi_write(4'h4, 32'h0000_005E, 4'hF, bresp_s, wlok);
                axi_read(4'h8, rd_s, rresp_s, rlok);
            join
            chk("sim_bresp", {30'b0, bresp_s}, 32'd0);
            chk("sim_rresp", {30'b0, rresp_s}, 32'd0);
            chk("sim_rdata", rd_s, 32'h0000_006B);
            chk("sim_latency", {30'b0, wlok, rlok}, 32'd3);
            chk("sim_counts", {(we_cnt - we0) == 1, (re_cnt - re0) == 1}, 32'd3);
            chk("sim_same_cycle", we_cyc, re_cyc);
            chk("sim_tx_data", {24'b0, last_tx}, 32'h5E);
        end

        // Write response back-pressure: bvalid must hold for 5 cycles.
        set_flags(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        s_axi_awaddr = 4'h4; s_axi_wdata = 32'h0000_0012; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) begin ok = 1'b1; break; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("bp_bvalid_seen", {31'b0, ok}, 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!s_axi_bvalid || s_axi_bresp != 2'b00) ok = 1'b0;
        end
        chk("bp_bvalid_stable", {31'b0, ok}, 32'd1);
        s_axi_bready = 1'b1;
        @(negedge clk);
        chk("bp_bvalid_drop", {31'b0, s_axi_bvalid}, 32'd0);

        // Read data back-pressure: rvalid and rdata must hold for 5 cycles.
        set_flags(1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
        re0 = re_cnt;
        @(negedge clk);
        s_axi_araddr = 4'h8; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_axi_rvalid) begin ok = 1'b1; break; end
        end
        s_axi_arvalid = 1'b0;
        chk("bp_rvalid_seen", {31'b0, ok}, 32'd1);
        rx_data = 8'h11;
        rx_empty = 1'b1;
        ok = 1'b1;
        held = s_axi_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!s_axi_rvalid || s_axi_rdata !== held) ok = 1'b0;
        end
        chk("bp_rvalid_stable", {31'b0, ok}, 32'd1);
        chk("bp_rdata_held", held, 32'h0000_00C3);
        chk("bp_rx_re_count", re_cnt - re0, 32'd1);
        s_axi_rready = 1'b1;
        @(negedge clk);
        chk("bp_rvalid_drop", {31'b0, s_axi_rvalid}, 32'd0);

`ifdef UART_AXIL_IRQ_EN
        // irq follows rx-not-empty with one cycle of latency.
        set_flags(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        axi_write(4'hC, 32'h0000_0001, 4'hF, resp, lok);
        @(negedge clk);
        chk("irq_idle", {31'b0, irq}, 32'd0);
        rx_empty = 1'b0;
        rx_data = 8'h42;
        #1;
        chk("irq_not_yet", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_rise", {31'b0, irq}, 32'd1);
        axi_read(4'h8, rd, resp, lok);
        chk("irq_pop_data", rd, 32'h0000_0042);
        rx_empty = 1'b1;
        #1;
        chk("irq_still_high", {31'b0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_fall", {31'b0, irq}, 32'd0);
        axi_write(4'hC, 32'h0000_0000, 4'hF, resp, lok);
`endif

        // Reset while the write FSM sits in W_RESP.
        set_flags(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        s_axi_awaddr = 4'h4; s_axi_wdata = 32'h0000_0021; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) begin ok = 1'b1; break; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("rstmid_bvalid_seen", {31'b0, ok}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_bvalid_drop", {31'b0, s_axi_bvalid}, 32'd0);
        @(negedge clk);
        chk("rstmid_still_idle", {31'b0, s_axi_bvalid}, 32'd0);
        rst_n = 1'b1;
        s_axi_bready = 1'b1;
        we0 = we_cnt;
        axi_write(4'h4, 32'h0000_0033, 4'hF, resp, lok);
        chk("rstmid_fresh_bresp", {30'b0, resp}, 32'd0);
        chk("rstmid_fresh_latency", {31'b0, lok}, 32'd1);
        chk("rstmid_fresh_push", we_cnt - we0, 32'd1);
        chk("rstmid_fresh_data", {24'b0, last_tx}, 32'h33);

        // Randomized transactions against the register-level model.
        m_drop = 1'b0;
        m_ie   = 3'b000;
        for (int it = 0; it < 300; it++) begin
            logic        is_wr;
            logic [1:0]  off;
            logic [31:0] data;
            logic [3:0]  strb;
            logic [31:0] exp_rd;
            int          exp_we, exp_re;
            set_flags($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), 8'($urandom));
            is_wr = $urandom_range(0, 1);
            off   = 2'($urandom_range(0, 3));
            data  = $urandom;
            strb  = 4'($urandom_range(0, 15));
            exp_we = 0;
            exp_re = 0;
            we0 = we_cnt;
            re0 = re_cnt;
            if (is_wr) begin
                axi_write({off, 2'b00}, data, strb, resp, lok);
                if (strb[0]) begin
                    if (off == 2'd1) begin
                        if (!tx_full) exp_we = 1;
                        else m_drop = 1'b1;
                    end else if (off == 2'd3) begin
                        if (data[4]) m_drop = 1'b0;
`ifdef UART_AXIL_IRQ_EN
                        m_ie = data[2:0];
`endif
                    end
                end
                chk("rnd_bresp", {30'b0, resp}, 32'd0);
                if (exp_we != 0) chk("rnd_tx_data", {24'b0, last_tx}, {24'b0, data[7:0]});
            end else begin
                case (off)
                    2'd0: exp_rd = {27'b0, m_drop, tx_full, tx_empty, rx_full, rx_empty};
                    2'd1: exp_rd = 32'h0;
                    2'd2: begin
                        exp_rd = rx_empty ? 32'h0000_0100 : {24'b0, rx_data};
                        exp_re = rx_empty ? 0 : 1;
                    end
                    default: exp_rd = {29'b0, m_ie};
                endcase
                axi_read({off, 2'b00}, rd, resp, lok);
                chk("rnd_rresp", {30'b0, resp}, 32'd0);
                chk($sformatf("rnd_rdata_off%0d", off), rd, exp_rd);
            end
            chk("rnd_latency", {31'b0, lok}, 32'd1);
            chk("rnd_tx_we_count", we_cnt - we0, exp_we);
            chk("rnd_rx_re_count", re_cnt - re0, exp_re);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
